rv32v_elem_sequencer: RTL and testbench
=======================================

# rv32v_elem_sequencer

Element sequencer for the vector pipeline. It accepts one vector instruction's active length from decode and steps through the elements NUM_LANES at a time. Each beat presents a lane-0 element offset and a per-lane active mask to the execute stage over a valid/ready handshake. The execute stage uses these to drive the vector register-file read offsets (vs1/vs2/vs3) and the writeback vd offset. The sequencer pulses done after the last beat is accepted.

## Interface
Parameters:
- NUM_LANES, 2: elements processed per beat; power of two, ≥1.
- VL_WIDTH, 5: VLMAX = 2**VL_WIDTH; vl is VL_WIDTH+1 bits.

Ports:
- CLK  in  1  clock. One clock; reset is synchronous and active-high.
- RST  in  1  synchronous active-high reset.
- start  in  1  launch request from decode; accepted only when start_ready=1.
- vl_in  in  VL_WIDTH+1  active vector length for the launched instruction.
- start_ready  out  1  high exactly when state is IDLE; combinational from state.
- flush  in  1  kill the current instruction; takes priority over every other input.
- out_valid  out  1  beat available to the execute stage.
- out_ready  in  1  execute stage accepts the beat.
- offset  out  VL_WIDTH  element index of lane 0 for the current beat.
- lane_active  out  NUM_LANES  bit i set iff offset+i < latched vl.
- first  out  1  current beat is beat 0.
- last  out  1  current beat is the final beat (offset+NUM_LANES ≥ vl).
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse; the instruction has completed normally.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches vl_eff = min(vl_in, VLMAX) and clears cnt to 0.
  - If vl_eff=0, go to DONE; otherwise go to RUN.
- RUN:
  - out_valid=1 throughout.
  - A handshake (out_valid & out_ready) advances cnt by NUM_LANES.
  - If the handshake occurs while last=1, go to DONE.
  - Without a handshake, all outputs hold stable.
- DONE: done=1 for this cycle only; go unconditionally to IDLE. start is ignored in DONE.
- flush=1 in any state forces IDLE next cycle with no done pulse. flush together with start in IDLE: flush wins and nothing is latched.
- cnt is held internally at VL_WIDTH+1 bits so that cnt+NUM_LANES does not overflow at vl=VLMAX; offset = cnt[VL_WIDTH-1:0].
- last is computed as (cnt + NUM_LANES ≥ vl_eff) using VL_WIDTH+2-bit arithmetic.
- lane_active, first and last are qualified by out_valid and are 0 outside RUN.
- start while busy is ignored; it is neither queued nor errored.

## Timing
- Reset values:
  - State IDLE, cnt=0, vl_eff=0.
  - out_valid=0, offset=0, lane_active=0, first=0, last=0.
  - busy=0, done=0, start_ready=1.
- Launch latency: start accepted at edge t; beat 0 is valid in cycle t+1.
- Number of beats = ceil(vl_eff / NUM_LANES). Zero stall cycles between beats while out_ready=1.
- Last handshake at cycle k: done=1 in cycle k+1; start_ready=1 in cycle k+2.
- vl_eff=0: DONE in cycle t+1, with no beats issued.
- RST asserted mid-operation returns all state to reset values at the next edge; no done pulse is generated.

## Structure
- Add typedef enum logic [1:0] {SEQ_IDLE, SEQ_RUN, SEQ_DONE} seq_state_t to rv32v_types_pkg, alongside the existing NUM_LANES and VL_WIDTH.
- One sub-module: rv32v_lane_mask_gen, a combinational block mapping (cnt, vl_eff) to lane_active and last. The execute stage can reuse it for tail masking.

## Test plan
- vl_in=5, NUM_LANES=2, out_ready=1: three beats with offset 0/2/4, lane_active 11/11/01, first on beat 0, last on beat 2; done one cycle after beat 2.
- vl_in=0: no out_valid ever asserted; done pulses in cycle t+1; start_ready returns in cycle t+2.
- vl_in=4 with out_ready low for 3 cycles on beat 1: offset=2 and lane_active=11 hold steady; beat count stays 2; done follows the second handshake.
- vl_in=32 (VLMAX): 16 beats, final offset=30 with last=1 and no counter wrap. vl_in=40: clamped, producing the same 16 beats.
- flush asserted on beat 1 of vl_in=8: IDLE next cycle with no done pulse; a start in the following cycle launches normally at offset 0.
- start asserted during RUN and during DONE: ignored, with vl_eff unchanged. RST asserted mid-RUN: all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/rv32v_types_pkg.sv
// Shared vector-pipeline constants and the element sequencer state encoding.
package rv32v_types_pkg;
  localparam int NUM_LANES = 2;
  localparam int VL_WIDTH  = 5;

  typedef enum logic [1:0] {SEQ_IDLE, SEQ_RUN, SEQ_DONE} seq_state_t;
endpackage

// File: rtl/rv32v_lane_mask_gen.sv
// Per-lane tail mask and final-beat flag for a beat starting at element cnt.
module rv32v_lane_mask_gen #(
  parameter int NUM_LANES = 2,
  parameter int VL_WIDTH  = 5
) (
  input  logic [VL_WIDTH:0]    cnt,
  input  logic [VL_WIDTH:0]    vl,
  output logic [NUM_LANES-1:0] lane_active,
  output logic                 last
);
  localparam int EW = VL_WIDTH + 2;

  logic [EW-1:0] cnt_ext;
  logic [EW-1:0] vl_ext;

  // One extra bit keeps cnt+NUM_LANES from wrapping when vl equals VLMAX.
  always_comb begin
    cnt_ext     = {1'b0, cnt};
    vl_ext      = {1'b0, vl};
    lane_active = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_active[i] = (cnt_ext + EW'(i)) < vl_ext;
    end
    last = (cnt_ext + EW'(NUM_LANES)) >= vl_ext;
  end
endmodule

// File: rtl/rv32v_elem_sequencer.sv
// Steps one vector instruction's elements NUM_LANES at a time, handing each
// beat (lane-0 offset plus active mask) to execute over valid/ready.
module rv32v_elem_sequencer
  import rv32v_types_pkg::*;
#(
  parameter int NUM_LANES = rv32v_types_pkg::NUM_LANES,
  parameter int VL_WIDTH  = rv32v_types_pkg::VL_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [VL_WIDTH:0]    vl_in,
  output logic                 start_ready,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [VL_WIDTH-1:0]  offset,
  output logic [NUM_LANES-1:0] lane_active,
  output logic                 first,
  output logic                 last,
  output logic                 busy,
  output logic                 done
);
  localparam logic [VL_WIDTH:0] VLMAX = {1'b1, {VL_WIDTH{1'b0}}};
  localparam logic [VL_WIDTH:0] STEP  = (VL_WIDTH+1)'(NUM_LANES);

  seq_state_t             state;
  seq_state_t             state_nxt;
  logic [VL_WIDTH:0]      cnt;
  logic [VL_WIDTH:0]      vl_eff;
  logic [VL_WIDTH:0]      vl_clamp;
  logic [NUM_LANES-1:0]   mask_raw;
  logic                   last_raw;
  logic                   launch;
  logic                   hs;

  assign vl_clamp = (vl_in > VLMAX) ? VLMAX : vl_in;
  assign launch   = (state == SEQ_IDLE) && start && !flush;
  assign hs       = (state == SEQ_RUN) && out_ready && !flush;

  rv32v_lane_mask_gen #(
    .NUM_LANES (NUM_LANES),
    .VL_WIDTH  (VL_WIDTH)
  ) u_mask (
    .cnt         (cnt),
    .vl          (vl_eff),
    .lane_active (mask_raw),
    .last        (last_raw)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= SEQ_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt    <= '0;
      vl_eff <= '0;
    end else if (launch) begin
      cnt    <= '0;
      vl_eff <= vl_clamp;
    end else if (hs) begin
      cnt <= cnt + STEP;
    end
  end

  // flush overrides every transition, including a start in IDLE.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = SEQ_IDLE;
    end else begin
      case (state)
        SEQ_IDLE: if (start) state_nxt = (vl_clamp == '0) ? SEQ_DONE : SEQ_RUN;
        SEQ_RUN:  if (out_ready && last_raw) state_nxt = SEQ_DONE;
        SEQ_DONE: state_nxt = SEQ_IDLE;
        default:  state_nxt = SEQ_IDLE;
      endcase
    end
  end

  always_comb begin
    out_valid   = (state == SEQ_RUN);
    start_ready = (state == SEQ_IDLE);
    busy        = (state != SEQ_IDLE);
    done        = (state == SEQ_DONE);
    offset      = cnt[VL_WIDTH-1:0];
    lane_active = out_valid ? mask_raw : '0;
    first       = out_valid && (cnt == '0);
    last        = out_valid && last_raw;
  end
endmodule

// File: tb/tb_rv32v_elem_sequencer.sv
// Scoreboard bench for rv32v_elem_sequencer at NUM_LANES=2, VL_WIDTH=5.
module tb_rv32v_elem_sequencer;
  typedef struct {
    logic [4:0] offset;
    logic [1:0] mask;
    logic       first;
    logic       last;
  } beat_t;

  logic       CLK;
  logic       RST;
  logic       start;
  logic [5:0] vl_in;
  logic       start_ready;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] offset;
  logic [1:0] lane_active;
  logic       first;
  logic       last;
  logic       busy;
  logic       done;

  int    n_cmp;
  int    n_err;
  beat_t sb[$];

  rv32v_elem_sequencer #(.NUM_LANES(2), .VL_WIDTH(5)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start),
    .vl_in       (vl_in),
    .start_ready (start_ready),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .offset      (offset),
    .lane_active (lane_active),
    .first       (first),
    .last        (last),
    .busy        (busy),
    .done        (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic test_reset();
    RST = 1'b1; start = 1'b0; vl_in = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge CLK);
    n_cmp++;
    if ({out_valid, offset, lane_active, first, last} !== 10'd0) begin
      n_err++;
      $display("FAIL reset_beat: got %b required 0000000000",
               {out_valid, offset, lane_active, first, last});
    end
    n_cmp++;
    if ({busy, done, start_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL reset_ctrl: busy/done/start_ready got %b required 001", {busy, done, start_ready});
    end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  // Pushes the model's beat list, launches vl, then pops and compares each
  // beat as it is handshaken; optionally stalls one beat and pokes start.
  task automatic test_stream(input string name, input int vl, input int stall_beat,
                             input int stall_cycles, input bit poke_start);
    int    eff;
    int    beat;
    int    stalls;
    bit    expect_done;
    bit    finished;
    beat_t b;
    beat_t got;
    eff = (vl > 32) ? 32 : vl;
    sb.delete();
    for (int c = 0; c < eff; c += 2) begin
      b.offset = 5'(c);
      b.mask   = {c + 1 < eff, c < eff};
      b.first  = (c == 0);
      b.last   = (c + 2 >= eff);
      sb.push_back(b);
    end
    @(negedge CLK);
    start = 1'b1; vl_in = 6'(vl); out_ready = 1'b1;
    @(negedge CLK);
    start = poke_start;
    if (poke_start) vl_in = 6'd7;
    expect_done = (eff == 0);
    beat = 0; stalls = 0; finished = 1'b0;
    for (int cyc = 0; cyc < 100 && !finished; cyc++) begin
      if (expect_done) begin
        n_cmp++;
        if ({done, out_valid, sb.size() == 0} !== 3'b101) begin
          n_err++;
          $display("FAIL %s_done: done/out_valid/queue_empty got %b required 101",
                   name, {done, out_valid, sb.size() == 0});
        end
        @(negedge CLK);
        start = 1'b0;
        n_cmp++;
        if ({start_ready, busy, done, out_valid} !== 4'b1000) begin
          n_err++;
          $display("FAIL %s_idle: start_ready/busy/done/out_valid got %b required 1000",
                   name, {start_ready, busy, done, out_valid});
        end
        finished = 1'b1;
      end else if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s_extra: out_valid=%b done=%b with no beat expected", name, out_valid, done);
        finished = 1'b1;
      end else begin
        got = sb[0];
        n_cmp++;
        if ({out_valid, offset, lane_active, first, last} !==
            {1'b1, got.offset, got.mask, got.first, got.last}) begin
          n_err++;
          $display("FAIL %s_beat%0d: valid/offset/mask/first/last got %b/%0d/%b/%b/%b required 1/%0d/%b/%b/%b",
                   name, beat, out_valid, offset, lane_active, first, last,
                   got.offset, got.mask, got.first, got.last);
        end
        if (beat == stall_beat && stalls < stall_cycles) begin
          out_ready = 1'b0;
          stalls++;
        end else begin
          out_ready = 1'b1;
          b = sb.pop_front();
          expect_done = b.last;
          beat++;
        end
        @(negedge CLK);
      end
    end
    if (!finished) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: no done within 100 cycles, %0d beats left", name, sb.size());
    end
    start = 1'b0; out_ready = 1'b1; vl_in = '0;
  endtask

  task automatic test_flush();
    @(negedge CLK);
    start = 1'b1; vl_in = 6'd8; out_ready = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if ({out_valid, offset} !== {1'b1, 5'd2}) begin
      n_err++;
      $display("FAIL flush_beat1: valid/offset got %b/%0d required 1/2", out_valid, offset);
    end
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    n_cmp++;
    if ({busy, out_valid, done, start_ready} !== 4'b0001) begin
      n_err++;
      $display("FAIL flush_idle: busy/out_valid/done/start_ready got %b required 0001",
               {busy, out_valid, done, start_ready});
    end
    flush = 1'b1; start = 1'b1; vl_in = 6'd5;
    @(negedge CLK);
    flush = 1'b0; start = 1'b0;
    n_cmp++;
    if ({busy, out_valid, done} !== 3'b000) begin
      n_err++;
      $display("FAIL flush_start: busy/out_valid/done got %b required 000", {busy, out_valid, done});
    end
    @(negedge CLK);
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL flush_nodone: done got %b required 0", done);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    start = 1'b1; vl_in = 6'd8; out_ready = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    n_cmp++;
    if ({out_valid, offset, lane_active, first, last, busy, done, start_ready} !== 13'b0000000000001) begin
      n_err++;
      $display("FAIL reset_mid: outputs got %b required 0000000000001",
               {out_valid, offset, lane_active, first, last, busy, done, start_ready});
    end
    @(negedge CLK);
    n_cmp++;
    if ({done, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_mid_after: done/busy got %b required 00", {done, busy});
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_stream("vl5", 5, -1, 0, 1'b0);
    test_stream("vl0", 0, -1, 0, 1'b0);
    test_stream("stall", 4, 1, 3, 1'b0);
    test_stream("vlmax", 32, -1, 0, 1'b0);
    test_stream("clamp", 40, -1, 0, 1'b0);
    test_stream("odd_stall", 7, 3, 2, 1'b0);
    test_stream("poke", 6, 1, 2, 1'b1);
    test_flush();
    test_stream("after_flush", 3, -1, 0, 1'b0);
    test_reset_mid();
    test_stream("after_reset", 2, 0, 1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
